channel_error_injector: RTL
===========================

Name: channel_error_injector

Overview:
- Parametrised channel model placed between the convolutional encoder output and the Viterbi decoder input.
- Registers each encoded symbol and corrupts selected ones by XOR with a flip mask.
- Corruption is triggered by an LFSR-based random rate or by a fixed symbol period, optionally stretched into bursts of consecutive bad symbols.
- Keeps saturating counts of symbols passed and symbols corrupted for BER measurement.

Parameters:
- SYM_W, 2: encoded symbol width in bits.
- LFSR_W, 16: width of the random-trigger LFSR.
- POLY, 16'hB400: Galois LFSR feedback mask (x^16+x^14+x^13+x^11+1).
- SEED, 16'hACE1: LFSR reset value; 0 is replaced by 1.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_mode  in  2  0 = pass-through, 1 = random, 2 = periodic, 3 = reserved (behaves as 0).
- cfg_rate  in  4  random mode: trigger when the low cfg_rate LFSR bits are all zero (probability 2^-cfg_rate).
- cfg_period  in  8  periodic mode: trigger on every cfg_period-th valid symbol; 0 = never.
- cfg_burst_len  in  4  symbols corrupted per trigger; 0 treated as 1.
- cfg_flip_mask  in  SYM_W  XOR pattern applied to corrupted symbols.
- clr_cnt  in  1  synchronous clear of statistics counters.
- valid_i  in  1  input symbol valid.
- sym_i  in  SYM_W  input symbol.
- valid_o  out  1  output symbol valid.
- sym_o  out  SYM_W  output symbol, possibly corrupted.
- err_o  out  1  the current output symbol was selected for corruption.
- sym_cnt  out  CNT_W  valid symbols passed, saturating.
- err_cnt  out  CNT_W  symbols corrupted, saturating.

Behaviour:
- Reset values:
  - valid_o, err_o, sym_o, sym_cnt, err_cnt = 0.
  - LFSR = SEED (or 1 if SEED = 0).
  - Period counter = 0; FSM = IDLE; burst remaining = 0.
- Latency: exactly 1 cycle. valid_o(t+1) = valid_i(t), with no backpressure.
- When valid_i = 0, the next cycle gives valid_o = 0 and err_o = 0. sym_o holds its value and no state advances: LFSR, period counter, burst counter and statistics all hold.
- LFSR: advances one Galois step per valid_i cycle, after its current value has been used for that symbol's trigger decision.
- Trigger, evaluated per valid symbol:
  - Mode 1: trig = (lfsr & ((1<<cfg_rate)-1)) == 0, so cfg_rate = 0 triggers every symbol.
  - Mode 2: period counter counts valid symbols 0..cfg_period-1 and wraps; trig when counter == cfg_period-1. Period counter runs only in mode 2 and resets to 0 on any change out of mode 2.
- Burst FSM:
  - IDLE: if trig, corrupt this symbol and set rem = max(cfg_burst_len,1)-1. If rem > 0, go to BURST.
  - BURST: corrupt every valid symbol and ignore triggers. rem decrements per corrupted symbol; return to IDLE after the symbol at which rem reaches 0. The period counter and LFSR keep running during BURST.
  - cfg_mode becoming 0 or 3 aborts immediately: FSM goes to IDLE, rem = 0, and the current symbol is not corrupted.
  - Other config changes mid-burst do not shorten or extend the burst.
- Corruption: sym_o = sym_i ^ cfg_flip_mask, err_o = 1.
  - err_o is asserted and counted even if cfg_flip_mask = 0; this is marker-only use.
- Counters:
  - sym_cnt increments per valid symbol; err_cnt increments per corrupted symbol. Both saturate at 2^CNT_W-1.
  - clr_cnt has priority: both counters become 0 and the coincident symbol is not counted.
  - clr_cnt does not affect the LFSR, the FSM or the data path.
- rst mid-burst: everything returns to reset values at once. The LFSR sequence restarts from SEED, so runs are repeatable.

Test Plan:
- Mode 0, 300 valid symbols with random sym_i -> sym_o equals sym_i delayed by 1 cycle; err_o never asserted; sym_cnt = 300; err_cnt = 0.
- Mode 2, period = 16, burst = 1, mask = 2'b01, 64 symbols -> symbols 15, 31, 47 and 63 have bit 0 inverted; err_cnt = 4.
- Mode 2, period = 8, burst = 3, mask = 2'b11 -> symbols 7, 8, 9 and 15, 16, 17 corrupted; triggers falling inside a burst are ignored.
- Mode 1, rate = 4, 4096 symbols after reset -> err_cnt matches the golden model of the POLY/SEED LFSR exactly (about 256); a second run after rst gives the identical err_o sequence.
- valid_i gaps (1 in 3 cycles idle) in mode 2, period = 4 -> corruption positions are counted in valid symbols only; idle cycles have valid_o = 0 and err_o = 0.
- Boundaries:
  - clr_cnt together with valid_i -> counters read 0 next cycle.
  - CNT_W forced to 4 -> sym_cnt holds at 15.
  - cfg_mode set to 0 mid-burst -> next symbol is uncorrupted.
  - rst during BURST -> all outputs 0 in the same cycle.

Source files
------------

// File: rtl/channel_error_injector.sv
`default_nettype none
// ============================================================================
//  Module      : channel_error_injector
//  Description : Channel model between convolutional encoder and Viterbi
//                decoder. Registers each symbol and XOR-corrupts selected ones,
//                triggered by an LFSR random rate or a fixed symbol period,
//                optionally stretched into bursts. Keeps saturating
//                symbol/error counters for BER measurement.
//  Revision    : 1.0 - initial release
// ============================================================================
module channel_error_injector #(
    parameter int                SYM_W  = 2,
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] POLY   = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED   = 16'hACE1,
    parameter int                CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       cfg_mode,
    input  logic [3:0]       cfg_rate,
    input  logic [7:0]       cfg_period,
    input  logic [3:0]       cfg_burst_len,
    input  logic [SYM_W-1:0] cfg_flip_mask,
    input  logic             clr_cnt,
    input  logic             valid_i,
    input  logic [SYM_W-1:0] sym_i,
    output logic             valid_o,
    output logic [SYM_W-1:0] sym_o,
    output logic             err_o,
    output logic [CNT_W-1:0] sym_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [LFSR_W-1:0] c_LFSR_INIT   = (SEED == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : SEED;
    localparam logic [CNT_W-1:0]  c_CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [1:0]        c_MODE_RANDOM = 2'd1;
    localparam logic [1:0]        c_MODE_PERIOD = 2'd2;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        rem_q, rem_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [7:0]        pcnt_q, pcnt_d;
    logic              valid_q;
    logic [SYM_W-1:0]  sym_q;
    logic              err_q;
    logic [CNT_W-1:0]  sym_cnt_q;
    logic [CNT_W-1:0]  err_cnt_q;

    logic [LFSR_W-1:0] w_rate_mask;
    logic [7:0]        w_period_last;
    logic [3:0]        w_burst_m1;
    logic              w_active;
    logic              w_trig;
    logic              w_corrupt;

    assign w_active      = (cfg_mode == c_MODE_RANDOM) || (cfg_mode == c_MODE_PERIOD);
    assign w_period_last = cfg_period - 8'd1;
    assign w_burst_m1    = (cfg_burst_len == 4'd0) ? 4'd0 : (cfg_burst_len - 4'd1);

    // Low cfg_rate bits of the LFSR form the random-trigger test mask.
    always_comb begin
        w_rate_mask = '0;
        for (int i = 0; i < LFSR_W; i++) begin
            if (i < int'(cfg_rate)) begin
                w_rate_mask[i] = 1'b1;
            end
        end
    end

    // Galois LFSR step (used after the current value decided this symbol).
    always_comb begin
        lfsr_d = lfsr_q;
        if (valid_i) begin
            lfsr_d = lfsr_q >> 1;
            if (lfsr_q[0]) begin
                lfsr_d = (lfsr_q >> 1) ^ POLY;
            end
        end
    end

    // Period counter counts valid symbols in periodic mode only; any other mode parks it at 0.
    always_comb begin
        pcnt_d = pcnt_q;
        if (cfg_mode != c_MODE_PERIOD) begin
            pcnt_d = 8'd0;
        end else if (valid_i && (cfg_period != 8'd0)) begin
            pcnt_d = (pcnt_q >= w_period_last) ? 8'd0 : (pcnt_q + 8'd1);
        end
    end

    // Trigger decision for the current valid symbol.
    always_comb begin
        w_trig = 1'b0;
        if (valid_i) begin
            if (cfg_mode == c_MODE_RANDOM) begin
                w_trig = ((lfsr_q & w_rate_mask) == '0);
            end else if ((cfg_mode == c_MODE_PERIOD) && (cfg_period != 8'd0)) begin
                w_trig = (pcnt_q == w_period_last);
            end
        end
    end

    // Burst FSM: a trigger corrupts this symbol and arms rem further ones; disabling the mode aborts.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        w_corrupt = 1'b0;
        if (!w_active) begin
            state_d = S_IDLE;
            rem_d   = 4'd0;
        end else if (valid_i) begin
            case (state_q)
                S_IDLE: begin
                    if (w_trig) begin
                        w_corrupt = 1'b1;
                        rem_d     = w_burst_m1;
                        if (w_burst_m1 != 4'd0) begin
                            state_d = S_BURST;
                        end
                    end
                end
                S_BURST: begin
                    w_corrupt = 1'b1;
                    rem_d     = rem_q - 4'd1;
                    if (rem_q <= 4'd1) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    rem_d   = 4'd0;
                end
            endcase
        end
    end

    // Control state registers: FSM, burst remainder, LFSR, period counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            rem_q   <= 4'd0;
            lfsr_q  <= c_LFSR_INIT;
            pcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            lfsr_q  <= lfsr_d;
            pcnt_q  <= pcnt_d;
        end
    end

    // One-cycle data path; sym_o holds across idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            sym_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_i;
            err_q   <= w_corrupt;
            if (valid_i) begin
                sym_q <= w_corrupt ? (sym_i ^ cfg_flip_mask) : sym_i;
            end
        end
    end

    // Saturating statistics; clr_cnt wins and drops the coincident symbol.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sym_cnt_q <= '0;
            err_cnt_q <= '0;
        end else if (clr_cnt) begin
            sym_cnt_q <= '0;
            err_cnt_q <= '0;
        end else if (valid_i) begin
            if (sym_cnt_q != '1) begin
                sym_cnt_q <= sym_cnt_q + c_CNT_ONE;
            end
            if (w_corrupt && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + c_CNT_ONE;
            end
        end
    end

    assign valid_o = valid_q;
    assign sym_o   = sym_q;
    assign err_o   = err_q;
    assign sym_cnt = sym_cnt_q;
    assign err_cnt = err_cnt_q;

endmodule
`default_nettype wire
